// File: rtl/tdc_phase_meter.sv
// tdc_phase_meter: measures clk cycles from a ref_in rising edge to the next sig_in rising edge.
// Optional result averaging is compiled in with PHASE_METER_AVG_EN. Revision 1.0.
`timescale 1ns/1ps
`default_nettype none

module tdc_phase_meter #(
    parameter int CNT_W    = 18,
    parameter int AVG_LOG2 = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ref_in,
    input  logic             sig_in,
    output logic [CNT_W-1:0] phase_cnt,
    output logic             phase_valid,
    output logic             timeout,
    output logic             busy
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_COUNT = 1'b1
    } state_t;

    logic r_ref_s1, r_ref_s2, r_ref_h;
    logic r_sig_s1, r_sig_s2, r_sig_h;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic [CNT_W-1:0] r_phase;
    logic             r_valid;
    logic             r_tmo;

    logic             w_ref_rise, w_sig_rise;
    logic             w_in_count, w_cnt_max;
    logic             w_done, w_tmo;
    logic [CNT_W-1:0] w_meas;

    // Both inputs see identical synchroniser depth, so the latency cancels in the interval.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ref_s1 <= 1'b0;
            r_ref_s2 <= 1'b0;
            r_ref_h  <= 1'b0;
            r_sig_s1 <= 1'b0;
            r_sig_s2 <= 1'b0;
            r_sig_h  <= 1'b0;
        end else begin
            r_ref_s1 <= ref_in;
            r_ref_s2 <= r_ref_s1;
            r_ref_h  <= r_ref_s2;
            r_sig_s1 <= sig_in;
            r_sig_s2 <= r_sig_s1;
            r_sig_h  <= r_sig_s2;
        end
    end

    assign w_ref_rise = r_ref_s2 & ~r_ref_h;
    assign w_sig_rise = r_sig_s2 & ~r_sig_h;
    assign w_in_count = (r_state == S_COUNT);
    assign w_cnt_max  = &r_cnt;

    // r_cnt holds the cycles elapsed since the ref-rise detection cycle, so it is the result directly.
    assign w_meas = w_in_count ? r_cnt : '0;
    assign w_done = en & w_sig_rise & (w_in_count | w_ref_rise);
    assign w_tmo  = en & w_in_count & ~w_sig_rise & (w_ref_rise | w_cnt_max);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else if (!en) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_ref_rise && !w_sig_rise) begin
                        r_state <= S_COUNT;
                        r_cnt   <= CNT_W'(1);
                        r_busy  <= 1'b1;
                    end
                end
                S_COUNT: begin
                    if (w_ref_rise) begin
                        r_cnt <= CNT_W'(1);
                    end else if (w_sig_rise || w_cnt_max) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    generate
        if (AVG_LOG2 < 1) begin : g_avg_log2_check
            $error("tdc_phase_meter: AVG_LOG2 must be at least 1");
        end
    endgenerate

`ifdef PHASE_METER_AVG_EN
    logic [CNT_W+AVG_LOG2-1:0] r_acc;
    logic [AVG_LOG2-1:0]       r_nsamp;
    logic [CNT_W+AVG_LOG2-1:0] w_acc_sum;

    assign w_acc_sum = r_acc + {{AVG_LOG2{1'b0}}, w_meas};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_phase <= '0;
            r_valid <= 1'b0;
            r_tmo   <= 1'b0;
            r_acc   <= '0;
            r_nsamp <= '0;
        end else if (!en) begin
            r_valid <= 1'b0;
            r_tmo   <= 1'b0;
            r_acc   <= '0;
            r_nsamp <= '0;
        end else begin
            r_valid <= 1'b0;
            r_tmo   <= w_tmo & ~w_done;
            if (w_done) begin
                if (&r_nsamp) begin
                    r_phase <= w_acc_sum[CNT_W+AVG_LOG2-1:AVG_LOG2];
                    r_valid <= 1'b1;
                    r_acc   <= '0;
                    r_nsamp <= '0;
                end else begin
                    r_acc   <= w_acc_sum;
                    r_nsamp <= r_nsamp + 1'b1;
                end
            end else if (w_tmo) begin
                r_acc   <= '0;
                r_nsamp <= '0;
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_phase <= '0;
            r_valid <= 1'b0;
            r_tmo   <= 1'b0;
        end else if (!en) begin
            r_valid <= 1'b0;
            r_tmo   <= 1'b0;
        end else begin
            r_valid <= w_done;
            r_tmo   <= w_tmo & ~w_done;
            if (w_done) begin
                r_phase <= w_meas;
            end
        end
    end
`endif

    assign phase_cnt   = r_phase;
    assign phase_valid = r_valid;
    assign timeout     = r_tmo;
    assign busy        = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_tdc_phase_meter.sv
// tb_tdc_phase_meter: randomized and directed stimulus against a timestamp-based reference model.
`timescale 1ns/1ps
`default_nettype none

module tb_tdc_phase_meter;

    localparam int CNT_W    = 10;
    localparam int AVG_LOG2 = 2;
    localparam int MAXC     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic             ref_in = 1'b0;
    logic             sig_in = 1'b0;
    logic [CNT_W-1:0] phase_cnt;
    logic             phase_valid;
    logic             timeout;
    logic             busy;

    always #5 clk = ~clk;

    tdc_phase_meter #(.CNT_W(CNT_W), .AVG_LOG2(AVG_LOG2)) dut (
        .clk(clk), .rst(rst), .en(en), .ref_in(ref_in), .sig_in(sig_in),
        .phase_cnt(phase_cnt), .phase_valid(phase_valid), .timeout(timeout), .busy(busy)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int n_valid_seen = 0;
    int n_tmo_seen   = 0;

    // Model: timestamps of detected edges; results appear on the next sampled cycle.
    bit lv_ref, lv_sig, lv_en;
    bit prev_ref, prev_sig;
    bit p_ref [2];
    bit p_sig [2];
    bit m_active;
    int m_t, m_tref, m_phase;
    int avg_sum, avg_n;
    bit e_valid, e_tmo, e_busy;
    int e_phase;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic complete(input int m);
`ifdef PHASE_METER_AVG_EN
        avg_sum += m;
        avg_n++;
        if (avg_n == (1 << AVG_LOG2)) begin
            m_phase = avg_sum / (1 << AVG_LOG2);
            e_valid = 1'b1;
            avg_sum = 0;
            avg_n   = 0;
        end
`else
        m_phase = m;
        e_valid = 1'b1;
`endif
    endtask

    task automatic discard();
        e_tmo   = 1'b1;
        avg_sum = 0;
        avg_n   = 0;
    endtask

    task automatic model_step(input bit rr, input bit sr, input bit en_now);
        e_valid = 1'b0;
        e_tmo   = 1'b0;
        m_t++;
        if (!en_now) begin
            m_active = 1'b0;
            avg_sum  = 0;
            avg_n    = 0;
        end else if (!m_active) begin
            if (rr && sr) complete(0);
            else if (rr) begin
                m_active = 1'b1;
                m_tref   = m_t;
            end
        end else begin
            if (sr) begin
                complete(m_t - m_tref);
                m_active = rr;
                m_tref   = m_t;
            end else if (rr) begin
                discard();
                m_tref = m_t;
            end else if (m_t - m_tref == MAXC) begin
                discard();
                m_active = 1'b0;
            end
        end
        e_busy  = m_active;
        e_phase = m_phase;
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_phase  = 0;
        avg_sum  = 0;
        avg_n    = 0;
        prev_ref = 1'b0;
        prev_sig = 1'b0;
        p_ref    = '{1'b0, 1'b0};
        p_sig    = '{1'b0, 1'b0};
        e_valid  = 1'b0;
        e_tmo    = 1'b0;
        e_busy   = 1'b0;
        e_phase  = 0;
    endtask

    task automatic tick();
        bit er, es;
        @(negedge clk);
        chk("phase_valid", phase_valid, e_valid);
        chk("timeout", timeout, e_tmo);
        chk("busy", busy, e_busy);
        chk("phase_cnt", phase_cnt, e_phase);
        if (phase_valid) n_valid_seen++;
        if (timeout) n_tmo_seen++;
        ref_in = lv_ref;
        sig_in = lv_sig;
        en     = lv_en;
        er = lv_ref & ~prev_ref;
        es = lv_sig & ~prev_sig;
        prev_ref = lv_ref;
        prev_sig = lv_sig;
        model_step(p_ref[1], p_sig[1], lv_en);
        p_ref[1] = p_ref[0];
        p_sig[1] = p_sig[0];
        p_ref[0] = er;
        p_sig[0] = es;
    endtask

    task automatic cycles(input int n);
        repeat (n) tick();
    endtask

    // ref rises, sig rises d cycles later, both drop again.
    task automatic measure(input int d);
        lv_ref = 1'b1;
        cycles(d);
        lv_sig = 1'b1;
        lv_ref = 1'b0;
        cycles(5);
        lv_sig = 1'b0;
        cycles(5);
    endtask

    initial begin
        int v0, t0;
        model_reset();
        m_t = 0;
        lv_ref = 1'b0;
        lv_sig = 1'b0;
        lv_en  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_phase_cnt", phase_cnt, 0);
        chk("reset_valid", phase_valid, 0);
        chk("reset_timeout", timeout, 0);
        chk("reset_busy", busy, 0);
        rst   = 1'b1;
        lv_en = 1'b1;
        cycles(5);

        // Simultaneous ref and sig rise from idle.
        lv_ref = 1'b1;
        lv_sig = 1'b1;
        cycles(4);
        lv_ref = 1'b0;
        lv_sig = 1'b0;
        cycles(4);
`ifndef PHASE_METER_AVG_EN
        chk("same_edge_phase", phase_cnt, 0);
`endif
        chk("same_edge_busy", busy, 0);

        measure(1000);
`ifndef PHASE_METER_AVG_EN
        chk("interval_1000", phase_cnt, 1000);
`endif
        chk("busy_after_1000", busy, 0);

        // Second ref rise without sig discards, then sig 50 cycles later.
        t0 = n_tmo_seen;
        lv_ref = 1'b1;
        cycles(300);
        lv_ref = 1'b0;
        cycles(300);
        measure(50);
        chk("ref_restart_timeouts", n_tmo_seen - t0, 1);
`ifndef PHASE_METER_AVG_EN
        chk("ref_restart_phase", phase_cnt, 50);
`endif

        // ref and sig rise together mid-count: 40 completes, 70 follows.
        t0 = n_tmo_seen;
        lv_ref = 1'b1;
        cycles(20);
        lv_ref = 1'b0;
        cycles(20);
        lv_ref = 1'b1;
        lv_sig = 1'b1;
        cycles(5);
        chk("overlap_busy", busy, 1);
        lv_ref = 1'b0;
        lv_sig = 1'b0;
        cycles(65);
        lv_sig = 1'b1;
        cycles(5);
        lv_sig = 1'b0;
        cycles(5);
        chk("overlap_timeouts", n_tmo_seen - t0, 0);
`ifndef PHASE_METER_AVG_EN
        chk("overlap_phase", phase_cnt, 70);
`endif

        // Counter saturation with sig held low.
        t0 = n_tmo_seen;
        lv_ref = 1'b1;
        cycles(10);
        lv_ref = 1'b0;
        cycles(1100);
        chk("overflow_timeouts", n_tmo_seen - t0, 1);
        chk("overflow_busy", busy, 0);

        // Enable dropped mid-measurement; the sig edge inside the gap is lost.
        v0 = n_valid_seen;
        lv_ref = 1'b1;
        cycles(20);
        lv_en = 1'b0;
        lv_sig = 1'b1;
        cycles(10);
        lv_en = 1'b1;
        lv_ref = 1'b0;
        lv_sig = 1'b0;
        cycles(30);
        chk("en_low_valids", n_valid_seen - v0, 0);
        chk("en_low_busy", busy, 0);

        // Reset 300 cycles into a measurement.
        lv_ref = 1'b1;
        cycles(300);
        lv_ref = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        ref_in = 1'b0;
        sig_in = 1'b0;
        #1;
        chk("midrst_phase", phase_cnt, 0);
        chk("midrst_valid", phase_valid, 0);
        chk("midrst_timeout", timeout, 0);
        chk("midrst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_reset();
        v0 = n_valid_seen;
        lv_sig = 1'b1;
        cycles(10);
        lv_sig = 1'b0;
        cycles(5);
        chk("midrst_no_valid", n_valid_seen - v0, 0);
        chk("midrst_phase_after", phase_cnt, 0);

        // Randomized square waves and occasional enable drops.
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(149) == 0) lv_ref = ~lv_ref;
            if ($urandom_range(59) == 0) lv_sig = ~lv_sig;
            if (lv_en) begin
                if ($urandom_range(1999) == 0) lv_en = 1'b0;
            end else if ($urandom_range(19) == 0) begin
                lv_en = 1'b1;
            end
            tick();
        end
        lv_ref = 1'b0;
        lv_sig = 1'b0;
        lv_en  = 1'b0;
        cycles(5);
        lv_en = 1'b1;
        cycles(5);

`ifdef PHASE_METER_AVG_EN
        v0 = n_valid_seen;
        measure(100);
        measure(101);
        measure(102);
        chk("avg_no_early_valid", n_valid_seen - v0, 0);
        measure(104);
        chk("avg_one_valid", n_valid_seen - v0, 1);
        chk("avg_phase", phase_cnt, 101);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tdc_phase_meter.md
TDC_PHASE_METER -- requirements
Module: tdc_phase_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 18: width of the interval counter and the result.
REQ-002 SHALL have parameter AVG_LOG2, default 4: log2 of the averaging depth when averaging is compiled in.
REQ-003 SHALL have port clk, input, 1: single clock for all logic.
REQ-004 SHALL have port rst, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port en, input, 1: synchronous measurement enable.
REQ-006 SHALL have port ref_in, input, 1: reference square wave from the phase controller, asynchronous.
REQ-007 SHALL have port sig_in, input, 1: returned or measured square wave, asynchronous.
REQ-008 SHALL have port phase_cnt, output, CNT_W: last published interval in clk cycles.
REQ-009 SHALL have port phase_valid, output, 1: single-cycle pulse when phase_cnt updates.
REQ-010 SHALL have port timeout, output, 1: single-cycle pulse when a measurement is discarded.
REQ-011 SHALL have port busy, output, 1: high while the FSM is in COUNT.

Function
REQ-012 SHALL pass ref_in and sig_in through identical 2-flop synchronisers plus one history flop each; rising edge = synced 1 and history 0. Equal depth cancels the synchroniser latency.
REQ-013 SHALL implement FSM states IDLE and COUNT.
REQ-014 IDLE: on ref rise, SHALL clear the counter and enter COUNT. If sig rise occurs in the same cycle, it SHALL instead complete a measurement of 0 and stay in IDLE.
REQ-015 COUNT: SHALL increment the counter once per cycle. On sig rise, the measurement SHALL be the number of cycles between the ref-rise detection cycle and the sig-rise detection cycle, and the FSM SHALL return to IDLE.
REQ-016 COUNT, ref rise without sig rise: SHALL pulse timeout, discard the current measurement, clear the counter and remain in COUNT, starting a new measurement from this edge.
REQ-017 COUNT, ref rise and sig rise in the same cycle: sig SHALL complete the current measurement, and ref SHALL start a new one (remain in COUNT, counter cleared).
REQ-018 COUNT, counter reaches 2^CNT_W-1 with no sig rise: SHALL pulse timeout and go to IDLE; the counter SHALL never wrap.
REQ-019 A completed measurement SHALL be published on the cycle after the sig-rise detection cycle (phase_cnt and phase_valid registered); phase_cnt SHALL hold between pulses.
REQ-020 en low: SHALL force IDLE, clear the counter and averaging state, and suppress phase_valid and timeout; the synchronisers SHALL keep running.
REQ-021 phase_valid and timeout SHALL never assert in the same cycle; if both occur together (REQ-017 case), the valid pulse takes priority and that cycle's timeout is not raised.

Reset
REQ-022 While rst is low: state IDLE; counter, accumulator, sample count, phase_cnt, phase_valid, timeout, busy and all synchroniser/history flops SHALL be 0.
REQ-023 An input already high at reset release SHALL produce one rising-edge detection; this is accepted behaviour.
REQ-024 Reset mid-measurement SHALL discard the measurement, with no valid or timeout pulse.

Configuration
REQ-025 Macro PHASE_METER_AVG_EN defined: each completed measurement SHALL be added to a (CNT_W+AVG_LOG2)-bit accumulator.
  - After 2^AVG_LOG2 measurements: phase_cnt = accumulator >> AVG_LOG2 (truncated), phase_valid pulses, accumulator and sample count clear.
  - A timeout SHALL clear the accumulator and sample count.
REQ-026 Macro PHASE_METER_AVG_EN undefined: every completed measurement SHALL be published directly, and no accumulator SHALL be built.

Verification
REQ-027 Macro off, en=1: ref rise, then sig rise 1000 cycles later -> one phase_valid pulse, phase_cnt=1000, busy low afterwards.
REQ-028 Macro off: ref and sig rise on the same clk edge from IDLE -> phase_valid pulse, phase_cnt=0, busy stays low.
REQ-029 Macro on, AVG_LOG2=2: intervals 100, 101, 102, 104 -> no pulse for the first three; after the fourth, phase_cnt=101 (407>>2).
REQ-030 Macro off: ref rises twice 200000 cycles apart with no sig rise, then sig rise 50 cycles after the second ref rise -> timeout pulse at the second ref rise, then phase_cnt=50.
REQ-031 Reset asserted 300 cycles into COUNT, then sig rise after release -> all outputs 0, no phase_valid, FSM in IDLE.
REQ-032 CNT_W=8, sig held low -> timeout pulse when the counter reaches 255, FSM returns to IDLE, busy drops.
